// File: rtl/zpu_sd_bridge.sv
// zpu_sd_bridge: ZPU to SD host block bridge with shared sector buffer.
// Define ZPU_SD_TIMEOUT_EN to add a 24-bit watchdog on the REQ state.
module zpu_sd_bridge #(
    parameter int DRIVES = 3,
    parameter int BUF_AW = 9
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       zpu_out2,
    input  logic [31:0]       zpu_out3,
    input  logic              zpu_data_wr,
    input  logic              zpu_data_rd,
    input  logic              zpu_io_wr,
    output logic [15:0]       zpu_in2,
    output logic [31:0]       zpu_in3,
    output logic [31:0]       sd_lba,
    output logic [DRIVES-1:0] sd_rd,
    output logic [DRIVES-1:0] sd_wr,
    input  logic              sd_ack,
    input  logic [BUF_AW-1:0] sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    input  logic [DRIVES-1:0] img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,
    input  logic [1:0]        img_type
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
    state_t state;

    logic [7:0]        mem [0:(1<<BUF_AW)-1];
    logic [BUF_AW-1:0] ptr;
    logic [7:0]        zpu_q;

    logic wr_d1, wr_d2, wr_d3, inc_pend, rd_q;
    logic rq_rd_q, rq_wr_q, ack_q, mnt_q;
    logic io_done, error, mount_tg, readonly;
    logic [2:0]  fileno;
    logic [1:0]  filetype;
    logic [31:0] filesize;

    logic wr_edge, rd_fall, rq_rd, rq_wr, mnt_edge, busy, drv_ok, timeout;
    logic [DRIVES-1:0] sel;
    logic [2:0] low_idx;
    logic unused;

    assign wr_edge  = wr_d2 & ~wr_d3;
    assign rd_fall  = rd_q & ~zpu_data_rd;
    assign rq_rd    = zpu_out2[1] & ~rq_rd_q;
    assign rq_wr    = zpu_out2[2] & ~rq_wr_q;
    assign mnt_edge = (|img_mounted) & ~mnt_q;
    assign busy     = (state == REQ) || (state == XFER);
    assign drv_ok   = |sel;
    assign unused   = ^{zpu_out2[31:6], img_size[63:32]};

    assign zpu_in2 = {6'b0, busy, error, readonly, filetype,
                      fileno, mount_tg, io_done};
    assign zpu_in3 = zpu_out2[0] ? filesize : {24'b0, zpu_q};

    // One-hot drive select; out-of-range drive numbers give an empty mask
    always_comb begin
        sel = '0;
        for (int i = 0; i < DRIVES; i++)
            sel[i] = (zpu_out2[5:3] == 3'(i));
    end

    // Lowest set mount bit wins when several images arrive together
    always_comb begin
        low_idx = '0;
        for (int i = DRIVES - 1; i >= 0; i--)
            if (img_mounted[i]) low_idx = 3'(i);
    end

    // Dual-port sector buffer: port A host, port B at the ZPU pointer
    always_ff @(posedge clk_sys) begin
        if (sd_buff_wr)
            mem[sd_buff_addr] <= sd_buff_dout;
        sd_buff_din <= mem[sd_buff_addr];
        if (wr_edge && !zpu_out2[0])
            mem[ptr] <= zpu_out3[7:0];
        zpu_q <= mem[ptr];
    end

    // ZPU strobe delay, buffer pointer and LBA register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_d1    <= 1'b0;
            wr_d2    <= 1'b0;
            wr_d3    <= 1'b0;
            rd_q     <= 1'b0;
            inc_pend <= 1'b0;
            ptr      <= '0;
            sd_lba   <= '0;
        end else begin
            wr_d1    <= zpu_data_wr;
            wr_d2    <= wr_d1;
            wr_d3    <= wr_d2;
            rd_q     <= zpu_data_rd;
            inc_pend <= wr_edge && !zpu_out2[0];
            if (wr_edge && zpu_out2[0])
                sd_lba <= zpu_out3;
            if (zpu_io_wr)
                ptr <= '0;
            else
                ptr <= ptr + BUF_AW'(inc_pend) + BUF_AW'(rd_fall);
        end
    end

`ifdef ZPU_SD_TIMEOUT_EN
    logic [23:0] wd;
    assign timeout = (wd == 24'hFF_FFFF);

    // Watchdog counts consecutive REQ cycles without an acknowledge
    always_ff @(posedge clk_sys) begin
        if (reset || state != REQ || sd_ack)
            wd <= '0;
        else
            wd <= wd + 24'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Request FSM: decode ZPU request edges and track the host handshake
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= IDLE;
            sd_rd   <= '0;
            sd_wr   <= '0;
            io_done <= 1'b0;
            error   <= 1'b0;
            rq_rd_q <= 1'b0;
            rq_wr_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            rq_rd_q <= zpu_out2[1];
            rq_wr_q <= zpu_out2[2];
            ack_q   <= sd_ack;
            unique case (state)
                IDLE: begin
                    if (rq_rd || rq_wr) begin
                        if (drv_ok) begin
                            if (rq_rd) sd_rd <= sel;
                            else       sd_wr <= sel;
                            io_done <= 1'b0;
                            error   <= 1'b0;
                            state   <= REQ;
                        end else begin
                            error   <= 1'b1;
                            io_done <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                        state <= XFER;
                    end else if (timeout) begin
                        sd_rd   <= '0;
                        sd_wr   <= '0;
                        error   <= 1'b1;
                        io_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                XFER: begin
                    if (ack_q && !sd_ack) begin
                        io_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Mount tracking: latch image info on a new mount
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mnt_q    <= 1'b0;
            mount_tg <= 1'b0;
            fileno   <= '0;
            filetype <= '0;
            readonly <= 1'b0;
            filesize <= '0;
        end else begin
            mnt_q <= |img_mounted;
            if (mnt_edge) begin
                fileno   <= low_idx;
                filetype <= img_type;
                readonly <= img_readonly;
                filesize <= img_size[31:0];
                mount_tg <= ~mount_tg;
            end
        end
    end

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// tb_zpu_sd_bridge: directed bench for the ZPU/SD bridge.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_zpu_sd_bridge;

    localparam int DRIVES = 3;
    localparam int BUF_AW = 9;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       zpu_out2 = '0;
    logic [31:0]       zpu_out3 = '0;
    logic              zpu_data_wr = 1'b0;
    logic              zpu_data_rd = 1'b0;
    logic              zpu_io_wr = 1'b0;
    logic [15:0]       zpu_in2;
    logic [31:0]       zpu_in3;
    logic [31:0]       sd_lba;
    logic [DRIVES-1:0] sd_rd;
    logic [DRIVES-1:0] sd_wr;
    logic              sd_ack = 1'b0;
    logic [BUF_AW-1:0] sd_buff_addr = '0;
    logic [7:0]        sd_buff_dout = '0;
    logic              sd_buff_wr = 1'b0;
    logic [7:0]        sd_buff_din;
    logic [DRIVES-1:0] img_mounted = '0;
    logic              img_readonly = 1'b0;
    logic [63:0]       img_size = '0;
    logic [1:0]        img_type = '0;

    int n_cmp = 0;
    int n_err = 0;

    zpu_sd_bridge #(.DRIVES(DRIVES), .BUF_AW(BUF_AW)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .zpu_out2     (zpu_out2),
        .zpu_out3     (zpu_out3),
        .zpu_data_wr  (zpu_data_wr),
        .zpu_data_rd  (zpu_data_rd),
        .zpu_io_wr    (zpu_io_wr),
        .zpu_in2      (zpu_in2),
        .zpu_in3      (zpu_in3),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .img_type     (img_type)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic clear_ptr();
        zpu_io_wr = 1'b1;
        tick(1);
        zpu_io_wr = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_cmp++;
        if (sd_lba !== 32'h0) begin
            n_err++;
            $display("FAIL rst_lba got %h want 0", sd_lba);
        end
        n_cmp++;
        if (sd_rd !== 3'b000 || sd_wr !== 3'b000) begin
            n_err++;
            $display("FAIL rst_req got rd=%b wr=%b want 0", sd_rd, sd_wr);
        end
        n_cmp++;
        if (zpu_in2 !== 16'h0) begin
            n_err++;
            $display("FAIL rst_in2 got %h want 0", zpu_in2);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_lba_write();
        zpu_out2 = 32'h1;
        zpu_out3 = 32'h0000_1234;
        zpu_data_wr = 1'b1;
        tick(1);
        zpu_data_wr = 1'b0;
        tick(2);
        n_cmp++;
        if (sd_lba !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL lba got %h want 00001234", sd_lba);
        end
        n_cmp++;
        if (zpu_in3 !== 32'h0) begin
            n_err++;
            $display("FAIL size_rst got %h want 0", zpu_in3);
        end
        tick(2);
        zpu_out2 = 32'h0;
    endtask

    task automatic test_buffer_write();
        clear_ptr();
        zpu_out3 = 32'h0000_003C;
        zpu_data_wr = 1'b1;
        tick(1);
        zpu_data_wr = 1'b0;
        tick(4);
        zpu_out3 = 32'h0000_007E;
        zpu_data_wr = 1'b1;
        tick(1);
        zpu_data_wr = 1'b0;
        tick(4);
        clear_ptr();
        n_cmp++;
        if (zpu_in3 !== 32'h3C) begin
            n_err++;
            $display("FAIL buf0 got %h want 3c", zpu_in3);
        end
        zpu_data_rd = 1'b1;
        tick(1);
        zpu_data_rd = 1'b0;
        tick(3);
        n_cmp++;
        if (zpu_in3 !== 32'h7E) begin
            n_err++;
            $display("FAIL buf1 got %h want 7e", zpu_in3);
        end
        clear_ptr();
    endtask

    task automatic test_block_read();
        zpu_out2 = 32'h0000_000A;
        tick(1);
        n_cmp++;
        if (sd_rd !== 3'b010 || sd_wr !== 3'b000) begin
            n_err++;
            $display("FAIL rd_req got rd=%b wr=%b want 010/000",
                     sd_rd, sd_wr);
        end
        n_cmp++;
        if (zpu_in2[9] !== 1'b1 || zpu_in2[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rd_busy got %b/%b want busy=1 done=0",
                     zpu_in2[9], zpu_in2[0]);
        end
        tick(2);
        n_cmp++;
        if (sd_rd !== 3'b010) begin
            n_err++;
            $display("FAIL rd_hold got %b want 010", sd_rd);
        end
        sd_ack = 1'b1;
        sd_buff_addr = '0;
        sd_buff_dout = 8'hA5;
        sd_buff_wr = 1'b1;
        tick(1);
        sd_buff_wr = 1'b0;
        n_cmp++;
        if (sd_rd !== 3'b000) begin
            n_err++;
            $display("FAIL rd_ack got %b want 000", sd_rd);
        end
        tick(9);
        n_cmp++;
        if (zpu_in2[0] !== 1'b0) begin
            n_err++;
            $display("FAIL xfer_done got %b want 0", zpu_in2[0]);
        end
        sd_ack = 1'b0;
        tick(1);
        n_cmp++;
        if (zpu_in2[0] !== 1'b1 || zpu_in2[9] !== 1'b0) begin
            n_err++;
            $display("FAIL rd_done got done=%b busy=%b want 1/0",
                     zpu_in2[0], zpu_in2[9]);
        end
        n_cmp++;
        if (sd_buff_din !== 8'hA5) begin
            n_err++;
            $display("FAIL host_rd got %h want a5", sd_buff_din);
        end
        zpu_out2 = 32'h0;
        clear_ptr();
        n_cmp++;
        if (zpu_in3 !== 32'h0000_00A5) begin
            n_err++;
            $display("FAIL zpu_rd got %h want 000000a5", zpu_in3);
        end
    endtask

    task automatic test_wrap();
        clear_ptr();
        zpu_data_rd = 1'b1;
        tick(1);
        zpu_data_rd = 1'b0;
        tick(2);
        n_cmp++;
        if (zpu_in3 !== 32'h7E) begin
            n_err++;
            $display("FAIL wrap_1 got %h want 7e", zpu_in3);
        end
        for (int i = 0; i < 511; i++) begin
            zpu_data_rd = 1'b1;
            tick(1);
            zpu_data_rd = 1'b0;
            tick(1);
        end
        tick(2);
        n_cmp++;
        if (zpu_in3 !== 32'hA5) begin
            n_err++;
            $display("FAIL wrap_512 got %h want a5", zpu_in3);
        end
    endtask

    task automatic test_bad_drive();
        zpu_out2 = 32'h0000_002A;
        tick(1);
        n_cmp++;
        if (sd_rd !== 3'b000 || sd_wr !== 3'b000) begin
            n_err++;
            $display("FAIL bad_req got rd=%b wr=%b want 0", sd_rd, sd_wr);
        end
        n_cmp++;
        if (zpu_in2[9:8] !== 2'b01 || zpu_in2[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bad_flags got busy/err=%b done=%b want 01/1",
                     zpu_in2[9:8], zpu_in2[0]);
        end
        zpu_out2 = 32'h0;
        tick(1);
    endtask

    task automatic test_simul_busy();
        zpu_out2 = 32'h0000_0006;
        tick(1);
        n_cmp++;
        if (sd_rd !== 3'b001 || sd_wr !== 3'b000) begin
            n_err++;
            $display("FAIL simul got rd=%b wr=%b want 001/000",
                     sd_rd, sd_wr);
        end
        n_cmp++;
        if (zpu_in2[8] !== 1'b0 || zpu_in2[0] !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr got err=%b done=%b want 0/0",
                     zpu_in2[8], zpu_in2[0]);
        end
        zpu_out2 = 32'h0;
        tick(1);
        zpu_out2 = 32'h0000_0014;
        tick(1);
        n_cmp++;
        if (sd_wr !== 3'b000 || sd_rd !== 3'b001) begin
            n_err++;
            $display("FAIL busy_ign got rd=%b wr=%b want 001/000",
                     sd_rd, sd_wr);
        end
        zpu_out2 = 32'h0;
        sd_ack = 1'b1;
        tick(3);
        sd_ack = 1'b0;
        tick(1);
        n_cmp++;
        if (zpu_in2[0] !== 1'b1 || sd_rd !== 3'b000) begin
            n_err++;
            $display("FAIL simul_done got done=%b rd=%b want 1/000",
                     zpu_in2[0], sd_rd);
        end
        tick(1);
    endtask

    task automatic test_mount();
        img_type = 2'b10;
        img_readonly = 1'b1;
        img_size = 64'd92176;
        img_mounted = 3'b110;
        tick(1);
        img_mounted = 3'b000;
        zpu_out2 = 32'h1;
        tick(1);
        n_cmp++;
        if (zpu_in2[7:1] !== 7'b1_10_001_1) begin
            n_err++;
            $display("FAIL mount1 got %b want 1100011", zpu_in2[7:1]);
        end
        n_cmp++;
        if (zpu_in3 !== 32'd92176) begin
            n_err++;
            $display("FAIL size1 got %0d want 92176", zpu_in3);
        end
        img_type = 2'b01;
        img_readonly = 1'b0;
        img_size = 64'h0000_0001_0000_0400;
        img_mounted = 3'b100;
        tick(1);
        img_mounted = 3'b000;
        tick(1);
        n_cmp++;
        if (zpu_in2[7:1] !== 7'b0_01_010_0) begin
            n_err++;
            $display("FAIL mount2 got %b want 0010100", zpu_in2[7:1]);
        end
        n_cmp++;
        if (zpu_in3 !== 32'h0000_0400) begin
            n_err++;
            $display("FAIL size2 got %h want 00000400", zpu_in3);
        end
        zpu_out2 = 32'h0;
    endtask

    task automatic test_reset_mid();
        zpu_out2 = 32'h0000_0012;
        tick(1);
        n_cmp++;
        if (sd_rd !== 3'b100) begin
            n_err++;
            $display("FAIL mid_req got %b want 100", sd_rd);
        end
        reset = 1'b1;
        zpu_out2 = 32'h0;
        tick(1);
        n_cmp++;
        if (sd_rd !== 3'b000 || zpu_in2 !== 16'h0 || sd_lba !== 32'h0) begin
            n_err++;
            $display("FAIL mid_rst got rd=%b in2=%h lba=%h want 0",
                     sd_rd, zpu_in2, sd_lba);
        end
        reset = 1'b0;
        sd_ack = 1'b1;
        tick(2);
        sd_ack = 1'b0;
        tick(2);
        n_cmp++;
        if (zpu_in2 !== 16'h0 || sd_rd !== 3'b000) begin
            n_err++;
            $display("FAIL mid_ack got in2=%h rd=%b want 0", zpu_in2, sd_rd);
        end
        n_cmp++;
        if (zpu_in3 !== 32'hA5) begin
            n_err++;
            $display("FAIL buf_keep got %h want a5", zpu_in3);
        end
    endtask

    initial begin
        test_reset();
        test_lba_write();
        test_buffer_write();
        test_block_read();
        test_wrap();
        test_bad_drive();
        test_simul_busy();
        test_mount();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
